// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if
//   Bundles the two handshakes seen by the FIFO read-side adapter:
//   the FIFO read port (read strobe, empty flag, registered read data)
//   and the downstream valid/ready stream.
//
//   master : the adapter (drives fifo_read, m_valid, m_data)
//   slave  : the surrounding FIFO + consumer (drives fifo_empty,
//            fifo_read_data, m_ready)
interface fifo_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_read;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_read_data,
        input  m_ready,
        output fifo_read,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_read_data,
        output m_ready,
        input  fifo_read,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Drains a synchronous FIFO (read strobe, one-cycle registered read data,
//   empty flag) and presents the words as a valid/ready stream. A 3-entry
//   circular buffer absorbs the read latency so one word per enabled cycle
//   is sustained. fifo_read depends only on reset, clk_enable, fifo_empty
//   and registered state, never on m_ready.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   clk_enable  global advance enable; when 0 all state holds
//   bus         fifo_stream_reader_if.master (FIFO read port + stream)
//   occupancy   words held in the internal buffer (0..3)
//   word_count  words delivered, wraps modulo 2**COUNT_WIDTH
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clk_enable,
    fifo_stream_reader_if.master   bus,
    output logic [1:0]             occupancy,
    output logic [COUNT_WIDTH-1:0] word_count
);

    logic [1:0]             occ;
    logic                   pend;
    logic [1:0]             rd_idx;
    logic [1:0]             wr_idx;
    logic [DATA_WIDTH-1:0]  mem [3];
    logic [COUNT_WIDTH-1:0] count;

    logic [2:0] fill;
    logic       capture;
    logic       pop;

    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Words held plus the word already requested; keeping this below 3
    // before issuing a read is what guarantees the buffer never overflows.
    assign fill = {1'b0, occ} + {2'b00, pend};

    assign bus.fifo_read = reset & clk_enable & ~bus.fifo_empty & (fill < 3'd3);
    assign bus.m_valid   = (occ != 2'd0);

    assign capture = clk_enable & pend;
    assign pop     = bus.m_valid & bus.m_ready & clk_enable;

    always_comb begin
        bus.m_data = mem[0];
        case (rd_idx)
            2'd1:    bus.m_data = mem[1];
            2'd2:    bus.m_data = mem[2];
            default: bus.m_data = mem[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ    <= '0;
            pend   <= 1'b0;
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else if (clk_enable) begin
            pend <= bus.fifo_read;

            if (capture) begin
                case (wr_idx)
                    2'd1:    mem[1] <= bus.fifo_read_data;
                    2'd2:    mem[2] <= bus.fifo_read_data;
                    default: mem[0] <= bus.fifo_read_data;
                endcase
                wr_idx <= next_idx(wr_idx);
            end

            if (pop) begin
                rd_idx <= next_idx(rd_idx);
                count  <= count + COUNT_WIDTH'(1);
            end

            case ({capture, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign occupancy  = occ;
    assign word_count = count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Directed bench for fifo_stream_reader. A queue-based FIFO model feeds
//   the DUT; a queue-based reference model of the buffered and in-flight
//   words predicts every output, checked on each falling edge. Directed
//   scenarios add hand-computed literal checks.
module tb_fifo_stream_reader;

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int CNT_MASK = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_enable;
    logic [1:0]    occupancy;
    logic [CW-1:0] word_count;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_enable(clk_enable),
        .bus       (bus.master),
        .occupancy (occupancy),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // FIFO contents and reference model state
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] mbuf[$];
    logic [DW-1:0] minfl[$];
    int            mcount = 0;

    // Event logs (written only by the edge process)
    int            cyc = 0;
    int            rd_log[$];
    int            v_log[$];
    logic [DW-1:0] vd_log[$];
    int            xfers = 0;
    int            rd_dis = 0;

    int  checks = 0;
    int  errors = 0;
    logic chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int rd_at(input int i);
        return (i < rd_log.size()) ? rd_log[i] : -100;
    endfunction

    function automatic int v_at(input int i);
        return (i < v_log.size()) ? v_log[i] : -100;
    endfunction

    function automatic logic [DW-1:0] vd_at(input int i);
        return (i < vd_log.size()) ? vd_log[i] : 8'hxx;
    endfunction

    // FIFO model, reference model and event logging on the active edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_read === 1'b1) rd_log.push_back(cyc);
        if (bus.fifo_read === 1'b1 && !clk_enable) rd_dis <= rd_dis + 1;
        if (bus.m_valid === 1'b1) begin
            v_log.push_back(cyc);
            vd_log.push_back(bus.m_data);
        end
        if (!reset) begin
            mbuf.delete();
            minfl.delete();
            mcount <= 0;
        end else if (clk_enable) begin
            if (bus.m_valid === 1'b1 && bus.m_ready) xfers <= xfers + 1;
            if (mbuf.size() != 0 && bus.m_ready) begin
                void'(mbuf.pop_front());
                mcount <= (mcount + 1) & CNT_MASK;
            end
            if (minfl.size() != 0) begin
                mbuf.push_back(minfl[0]);
                minfl.delete();
            end
            if (bus.fifo_read === 1'b1 && fifo_q.size() != 0) begin
                bus.fifo_read_data <= fifo_q[0];
                minfl.push_back(fifo_q[0]);
                void'(fifo_q.pop_front());
            end
        end
        bus.fifo_empty <= (fifo_q.size() == 0);
    end

    // Per-cycle comparison against the reference model
    always @(negedge clk) begin
        if (chk_on) begin
            check("fifo_read", 32'(bus.fifo_read),
                  (reset && clk_enable && !bus.fifo_empty && (mbuf.size() + minfl.size() < 3)) ? 1 : 0);
            check("m_valid", 32'(bus.m_valid), (mbuf.size() != 0) ? 1 : 0);
            check("occupancy", 32'(occupancy), mbuf.size());
            check("word_count", 32'(word_count), mcount);
            if (mbuf.size() != 0) check("m_data", 32'(bus.m_data), 32'(mbuf[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fifo_q.delete();
        tick();
        reset = 1'b1;
    endtask

    task automatic run_until_drained(input string name, input int limit);
        int n = 0;
        while ((fifo_q.size() != 0 || mbuf.size() != 0 || minfl.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        check(name, (n < limit) ? 1 : 0, 1);
    endtask

    initial begin
        int rb, vb, xb, db, n;
        reset          = 1'b0;
        clk_enable     = 1'b1;
        bus.m_ready    = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(8'hC0 + 8'(i));

        // Reset held for 3 cycles with a non-empty FIFO
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst fifo_read", 32'(bus.fifo_read), 0);
            check("rst m_valid", 32'(bus.m_valid), 0);
            check("rst m_data", 32'(bus.m_data), 0);
            check("rst occupancy", 32'(occupancy), 0);
            check("rst word_count", 32'(word_count), 0);
            chk_on = 1'b1;
        end
        reset       = 1'b1;
        bus.m_ready = 1'b1;
        run_until_drained("rst drain", 50);
        tick();
        check("rst drain count", 32'(word_count), 4);

        // Single word
        do_reset();
        rb = rd_log.size(); vb = v_log.size();
        bus.m_ready = 1'b1;
        fifo_q.push_back(8'hA5);
        repeat (8) tick();
        check("single reads", rd_log.size() - rb, 1);
        check("single valid cycles", v_log.size() - vb, 1);
        check("single latency", v_at(vb) - rd_at(rb), 2);
        check("single data", 32'(vd_at(vb)), 32'h A5);
        check("single count", 32'(word_count), 1);

        // Continuous stream of 8 words
        do_reset();
        rb = rd_log.size(); vb = v_log.size();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(i));
        repeat (14) tick();
        check("stream valid cycles", v_log.size() - vb, 8);
        check("stream latency", v_at(vb) - rd_at(rb), 2);
        check("stream continuous", v_at(vb + 7) - v_at(vb), 7);
        for (int i = 0; i < 8; i++) check("stream order", 32'(vd_at(vb + i)), i);
        check("stream count", 32'(word_count), 8);

        // Backpressure
        do_reset();
        rb = rd_log.size(); xb = xfers;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(i));
        repeat (10) tick();
        check("bp reads", rd_log.size() - rb, 3);
        check("bp occupancy", 32'(occupancy), 3);
        check("bp m_valid", 32'(bus.m_valid), 1);
        check("bp m_data", 32'(bus.m_data), 0);
        bus.m_ready = 1'b1;
        run_until_drained("bp drain", 40);
        tick();
        check("bp transfers", xfers - xb, 8);
        check("bp count", 32'(word_count), 8);

        // Enable gating with random backpressure
        do_reset();
        xb = xfers; db = rd_dis;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h10 + 8'(i));
        n = 0;
        while ((fifo_q.size() != 0 || mbuf.size() != 0 || minfl.size() != 0) && n < 200) begin
            clk_enable  = (n % 2 == 0);
            bus.m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        check("gate drain", (n < 200) ? 1 : 0, 1);
        clk_enable = 1'b1;
        bus.m_ready = 1'b1;
        tick();
        check("gate reads while disabled", rd_dis - db, 0);
        check("gate transfers", xfers - xb, 8);
        check("gate count", 32'(word_count), 8);

        // Reset mid-stream with two words buffered and one in flight
        do_reset();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'h30 + 8'(i));
        bus.m_ready = 1'b1;
        repeat (4) tick();
        bus.m_ready = 1'b0;
        n = 0;
        while (!(occupancy == 2'd2 && minfl.size() == 1) && n < 20) begin
            tick();
            n++;
        end
        check("mid reach occ2 pend1", (n < 20) ? 1 : 0, 1);
        check("mid pre count nonzero", (word_count != '0) ? 1 : 0, 1);
        reset = 1'b0;
        fifo_q.delete();
        tick();
        check("mid m_valid", 32'(bus.m_valid), 0);
        check("mid occupancy", 32'(occupancy), 0);
        check("mid word_count", 32'(word_count), 0);
        check("mid fifo_read", 32'(bus.fifo_read), 0);
        reset = 1'b1;
        repeat (3) tick();

        // Counter wrap: 17 words on a 4-bit counter
        do_reset();
        xb = xfers;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 17; i++) fifo_q.push_back(8'h40 + 8'(i));
        run_until_drained("wrap drain", 60);
        tick();
        check("wrap transfers", xfers - xb, 17);
        check("wrap count", 32'(word_count), 1);

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
